// File: rtl/rv32_pkg.sv
// Shared RV32 core types: fetch, branch and fetch-queue packets.
package rv32_pkg;

    // Fetch stage output; mem_ready marks a valid arrival this cycle.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        mem_ready;
    } rv32_if_packet_t;

    // Branch resolution; branch_taken redirects fetch.
    typedef struct packed {
        logic        branch_taken;
        logic [31:0] branch_target;
    } rv32_branch_packet_t;

    // Fetch queue head entry presented to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } rv32_fq_packet_t;

    localparam int unsigned FQ_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with early fetch
// stall, sticky overflow flag and post-redirect wrong-path discard.
module fetch_queue
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH      = FQ_DEFAULT_DEPTH,
    parameter int unsigned SKID       = 2,
    parameter int unsigned FLUSH_DROP = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  rv32_if_packet_t     if_packet_in,
    input  rv32_branch_packet_t branch_packet,
    input  logic                id_ready,
    output rv32_fq_packet_t     fq_packet_out,
    output logic                fq_valid,
    output logic                stall_fetch,
    output logic                overflow_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = (FLUSH_DROP < 1) ? 1 : $clog2(FLUSH_DROP + 1);

    localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] C_STALL = CW'(DEPTH - SKID);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);
    localparam logic [DW-1:0] D_LOAD  = DW'(FLUSH_DROP);

    rv32_fq_packet_t r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_drop_cnt;
    logic            r_overflow;

    logic w_flush;
    logic w_full;
    logic w_arrive;
    logic w_pop;
    logic w_push;
    logic w_lost;
    logic w_unused_target;

    assign w_unused_target = ^branch_packet.branch_target;

    // Handshake qualification: a flush overrides any same-cycle push or pop.
    always_comb begin
        w_flush  = branch_packet.branch_taken;
        w_full   = (r_count == C_FULL);
        w_arrive = if_packet_in.mem_ready && !w_flush && (r_drop_cnt == '0);
        w_pop    = fq_valid && id_ready && !w_flush;
        w_push   = w_arrive && (!w_full || w_pop);
        w_lost   = w_arrive && w_full && !w_pop;
    end

    // Entry storage, cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: if_packet_in.pc, instruction: if_packet_in.instruction};
        end
    end

    // Pointer and occupancy update; pointers wrap explicitly for any DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Wrong-path discard window after a redirect; a new flush restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
        end else if (w_flush) begin
            r_drop_cnt <= D_LOAD;
        end else if (r_drop_cnt != '0) begin
            r_drop_cnt <= r_drop_cnt - DW'(1);
        end
    end

    // Sticky record of an arrival lost to a full queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_lost) begin
            r_overflow <= 1'b1;
        end
    end

    // Outputs derive from registered state only, so fetch sees no input loop.
    always_comb begin
        fq_packet_out = r_mem[r_rd_ptr];
        fq_valid      = (r_count != '0);
        stall_fetch   = (r_count >= C_STALL);
        overflow_err  = r_overflow;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4 and DEPTH=3 instances).
module tb_fetch_queue;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    rv32_if_packet_t     if_a, if_b;
    rv32_branch_packet_t br_a, br_b;
    logic                idr_a, idr_b;
    rv32_fq_packet_t     out_a, out_b;
    logic                v_a, s_a, o_a;
    logic                v_b, s_b, o_b;
    logic [66:0]         obs_a;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .SKID(2), .FLUSH_DROP(2)) u_dut_a (
        .clk(clk), .resetn(resetn), .if_packet_in(if_a), .branch_packet(br_a),
        .id_ready(idr_a), .fq_packet_out(out_a), .fq_valid(v_a),
        .stall_fetch(s_a), .overflow_err(o_a)
    );

    fetch_queue #(.DEPTH(3), .SKID(2), .FLUSH_DROP(2)) u_dut_b (
        .clk(clk), .resetn(resetn), .if_packet_in(if_b), .branch_packet(br_b),
        .id_ready(idr_b), .fq_packet_out(out_b), .fq_valid(v_b),
        .stall_fetch(s_b), .overflow_err(o_b)
    );

    assign obs_a = {v_a, s_a, o_a, out_a.pc, out_a.instruction};

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    // {fq_valid, stall_fetch, overflow_err, pc, instruction}
    function automatic logic [66:0] full_exp(input logic v, input logic s,
                                             input logic o, input logic [31:0] pc);
        return {v, s, o, pc, ins_of(pc)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive_a(input logic [31:0] pc);
        if_a = '{pc: pc, instruction: ins_of(pc), mem_ready: 1'b1};
    endtask

    task automatic idle_a();
        if_a = '0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_a(); br_a = '0; idr_a = 1'b0;
        if_b = '0; br_b = '0; idr_b = 1'b0;
        step(); step();
        n_checks++;
        if (obs_a !== 67'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs_a, 67'd0);
        end
        resetn = 1'b1;
        step();
        n_checks++;
        if (obs_a[66:64] !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_release_flags: got %b expected 000", obs_a[66:64]);
        end
    endtask

    task automatic test_in_order();
        idr_a = 1'b1;
        arrive_a(32'h0); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h0)) begin
            n_errors++;
            $display("FAIL order_pc0: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h0));
        end
        arrive_a(32'h4); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h4)) begin
            n_errors++;
            $display("FAIL order_pc4: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h4));
        end
        arrive_a(32'h8); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h8)) begin
            n_errors++;
            $display("FAIL order_pc8: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h8));
        end
        idle_a(); step();
        n_checks++;
        if (obs_a[66:64] !== 3'b000) begin
            n_errors++;
            $display("FAIL order_drained: got %b expected 000", obs_a[66:64]);
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] pcs [4];
        logic        stall_exp [4];
        pcs = '{32'h10, 32'h14, 32'h18, 32'h1C};
        stall_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
        idr_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arrive_a(pcs[i]); step();
            n_checks++;
            if (obs_a !== full_exp(1, stall_exp[i], 0, 32'h10)) begin
                n_errors++;
                $display("FAIL fill_%0d: got %h expected %h", i, obs_a,
                         full_exp(1, stall_exp[i], 0, 32'h10));
            end
        end
    endtask

    task automatic test_full_pushpop();
        idr_a = 1'b1;
        arrive_a(32'h24); step();
        n_checks++;
        if (obs_a !== full_exp(1, 1, 0, 32'h14)) begin
            n_errors++;
            $display("FAIL full_pushpop: got %h expected %h", obs_a, full_exp(1, 1, 0, 32'h14));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] pcs [4];
        logic        stall_exp [4];
        idr_a = 1'b0;
        arrive_a(32'h28); step();
        n_checks++;
        if (obs_a !== full_exp(1, 1, 1, 32'h14)) begin
            n_errors++;
            $display("FAIL overflow_set: got %h expected %h", obs_a, full_exp(1, 1, 1, 32'h14));
        end
        // Drain: the 4 surviving entries must come out, 0x28 must not.
        pcs = '{32'h18, 32'h1C, 32'h24, 32'h0};
        stall_exp = '{1'b1, 1'b1, 1'b0, 1'b0};
        idle_a(); idr_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_a !== full_exp(1, stall_exp[i], 1, pcs[i])) begin
                n_errors++;
                $display("FAIL drain_%0d: got %h expected %h", i, obs_a,
                         full_exp(1, stall_exp[i], 1, pcs[i]));
            end
        end
        step();
        n_checks++;
        if (obs_a[66:64] !== 3'b001) begin
            n_errors++;
            $display("FAIL drain_empty: got %b expected 001", obs_a[66:64]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] dropped [2];
        pulse_reset();
        idr_a = 1'b0;
        arrive_a(32'h40); step();
        arrive_a(32'h44); step();
        arrive_a(32'h48); step();
        n_checks++;
        if (obs_a !== full_exp(1, 1, 0, 32'h40)) begin
            n_errors++;
            $display("FAIL flush_prefill: got %h expected %h", obs_a, full_exp(1, 1, 0, 32'h40));
        end
        br_a.branch_taken = 1'b1; arrive_a(32'h4C); idr_a = 1'b1;
        step();
        br_a.branch_taken = 1'b0;
        n_checks++;
        if (obs_a[66:64] !== 3'b000) begin
            n_errors++;
            $display("FAIL flush_empty: got %b expected 000", obs_a[66:64]);
        end
        dropped = '{32'h50, 32'h54};
        for (int i = 0; i < 2; i++) begin
            arrive_a(dropped[i]); step();
            n_checks++;
            if (obs_a[66:64] !== 3'b000) begin
                n_errors++;
                $display("FAIL flush_drop_%0d: got %b expected 000", i, obs_a[66:64]);
            end
        end
        arrive_a(32'h100); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h100)) begin
            n_errors++;
            $display("FAIL flush_target: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h100));
        end
        // Back-to-back flushes: the second one restarts the discard window.
        idr_a = 1'b0; idle_a(); br_a.branch_taken = 1'b1; step();
        arrive_a(32'h104); step();
        br_a.branch_taken = 1'b0;
        arrive_a(32'h108); step();
        arrive_a(32'h10C); step();
        n_checks++;
        if (obs_a[66:64] !== 3'b000) begin
            n_errors++;
            $display("FAIL reflush_drop: got %b expected 000", obs_a[66:64]);
        end
        arrive_a(32'h110); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h110)) begin
            n_errors++;
            $display("FAIL reflush_target: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h110));
        end
        idle_a(); idr_a = 1'b1; step();
        idr_a = 1'b0;
    endtask

    task automatic test_wrap_depth3();
        logic [31:0] q [$];
        logic [15:0] pat;
        int          next_i;
        int          popped;
        logic        pop;
        logic        arrive;
        logic [31:0] pc;
        pat = 16'b1101_0110_1001_1000;
        next_i = 0;
        popped = 0;
        for (int cyc = 0; cyc < 60 && popped < 7; cyc++) begin
            idr_b = pat[cyc % 16];
            pop = (q.size() != 0) && idr_b;
            arrive = (next_i < 7) && ((q.size() < 3) || pop);
            pc = 32'h200 + 32'(next_i) * 4;
            if (arrive) if_b = '{pc: pc, instruction: ins_of(pc), mem_ready: 1'b1};
            else        if_b = '0;
            n_checks++;
            if (v_b !== (q.size() != 0)) begin
                n_errors++;
                $display("FAIL wrap_valid_c%0d: got %b expected %b", cyc, v_b, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if ({out_b.pc, out_b.instruction} !== {q[0], ins_of(q[0])}) begin
                    n_errors++;
                    $display("FAIL wrap_head_c%0d: got %h/%h expected %h/%h", cyc,
                             out_b.pc, out_b.instruction, q[0], ins_of(q[0]));
                end
            end
            step();
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (arrive) begin
                q.push_back(pc);
                next_i++;
            end
        end
        if_b = '0; idr_b = 1'b0;
        n_checks++;
        if (popped !== 7 || v_b !== 1'b0 || o_b !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_complete: got popped=%0d valid=%b ovf=%b expected popped=7 valid=0 ovf=0",
                     popped, v_b, o_b);
        end
    endtask

    task automatic test_async_reset();
        idr_a = 1'b0;
        arrive_a(32'h3000); step();
        arrive_a(32'h3004); step();
        arrive_a(32'h3008); step();
        idle_a();
        n_checks++;
        if (obs_a !== full_exp(1, 1, 0, 32'h3000)) begin
            n_errors++;
            $display("FAIL areset_prefill: got %h expected %h", obs_a, full_exp(1, 1, 0, 32'h3000));
        end
        #3;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== 67'd0) begin
            n_errors++;
            $display("FAIL areset_immediate: got %h expected %h", obs_a, 67'd0);
        end
        step();
        resetn = 1'b1;
        arrive_a(32'h3100); step();
        n_checks++;
        if (obs_a !== full_exp(1, 0, 0, 32'h3100)) begin
            n_errors++;
            $display("FAIL areset_first: got %h expected %h", obs_a, full_exp(1, 0, 0, 32'h3100));
        end
        idle_a(); idr_a = 1'b1; step();
        n_checks++;
        if (obs_a[66:64] !== 3'b000) begin
            n_errors++;
            $display("FAIL areset_single: got %b expected 000", obs_a[66:64]);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_stall();
        test_full_pushpop();
        test_overflow();
        test_flush();
        test_wrap_depth3();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the instruction fetch stage and the decode stage of the in-order single-issue core. It captures every valid fetched instruction (PC plus instruction word) into a small circular FIFO and presents the oldest one to decode with a valid/ready handshake. It drives the fetch stall early enough to absorb fetches already in flight, and discards the whole queue and wrong-path arrivals when a branch redirects fetch.

## Interface
- DEPTH, 4, number of entries; legal range 3..16.
- SKID, 2, slots reserved for fetches in flight after stall_fetch asserts; must be < DEPTH.
- FLUSH_DROP, 2, cycles of fetch arrivals discarded after a redirect.

- clk  input  1  clock, all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- if_packet_in  input  rv32_if_packet_t  from fetch: pc[31:0], instruction[31:0], mem_ready (arrival valid).
- branch_packet  input  rv32_branch_packet_t  branch_taken is the flush; branch_target is unused.
- id_ready  input  1  decode accepts the head entry this cycle.
- fq_packet_out  output  rv32_fq_packet_t  head entry: pc[31:0], instruction[31:0].
- fq_valid  output  1  head entry is valid.
- stall_fetch  output  1  to fetch; asserted when count >= DEPTH-SKID.
- overflow_err  output  1  sticky; an arrival was lost because the queue was full.

## Operation
- Storage: DEPTH entries, wr_ptr and rd_ptr of $clog2(DEPTH) bits, count of $clog2(DEPTH+1) bits.
  - Pointers wrap from DEPTH-1 to 0 explicitly, so non-power-of-2 depths work.
- push = mem_ready && !flush && drop_cnt==0.
- pop = fq_valid && id_ready && !flush.
- Push when full:
  - With pop in the same cycle: accepted.
  - Without pop: the entry is discarded and overflow_err sets; it clears only on reset.
- Push and pop together: count unchanged, both pointers advance.
- Flush (branch_taken=1):
  - Next edge sets count=0 and rd_ptr=wr_ptr=0.
  - Any same-cycle push or pop is ignored.
  - drop_cnt loads FLUSH_DROP.
- drop_cnt != 0: decrements by 1 per cycle, and arrivals are discarded.
  - A flush while drop_cnt != 0 reloads FLUSH_DROP.
- fq_packet_out = entry[rd_ptr] (combinational read of the array). Contents are don't-care when fq_valid=0.
- fq_valid = (count != 0).
- stall_fetch: combinational from registered count only, never from inputs, so there is no loop with fetch.
- Reset values:
  - count, pointers, drop_cnt = 0.
  - fq_valid, stall_fetch, overflow_err = 0.
  - fq_packet_out = 0; entries are cleared on reset.

## Timing
- Arrival at edge t (mem_ready=1) becomes visible on fq_valid/fq_packet_out after edge t. Latency is 1 cycle; there is no bypass.
- Pop at edge t: the next entry is visible after edge t, giving 1 instruction/cycle sustained throughput.
- stall_fetch reflects count after each edge. SKID=2 covers the registered fetch enable plus one memory cycle, so no overflow occurs when fetch honours the stall.
- Flush at edge t: fq_valid=0 after edge t.
  - Arrivals at edges t+1..t+FLUSH_DROP are discarded.
  - The first redirected instruction is accepted at edge t+FLUSH_DROP+1.
- Asynchronous reset mid-operation clears all state immediately; all outputs read their reset values while resetn=0.

## Structure
- rv32_pkg gains:
  - rv32_fq_packet_t {pc[31:0], instruction[31:0]}.
  - Constant FQ_DEFAULT_DEPTH=4.
- Reuses the existing rv32_if_packet_t and rv32_branch_packet_t types.
- Single module, with no sub-module. Pointer/count control and storage are small enough to live together.

## Test plan
- Reset, then 3 arrivals of pc 0x0/0x4/0x8 with id_ready=1:
  - fq_valid rises the cycle after the first arrival.
  - Outputs appear in order 0x0, 0x4, 0x8.
  - count never exceeds 1.
- id_ready=0, arrivals each cycle:
  - stall_fetch=1 once count=2.
  - A further 2 in-flight arrivals are accepted (count=4, full).
  - A 5th arrival sets overflow_err=1; count stays 4.
- Full queue, simultaneous arrival and id_ready=1:
  - Arrival is accepted, count stays 4, overflow_err stays 0.
  - Head advances by one PC.
- Queue holds 3 entries, branch_taken=1 with a same-cycle arrival and pop:
  - Next cycle count=0 and fq_valid=0.
  - Next 2 arrivals are dropped; the 3rd (pc 0x100) appears at the head.
- Wrap-around at DEPTH=3:
  - Push and pop 7 sequential PCs with a random id_ready pattern.
  - Output order matches input order exactly, with no loss or duplication.
- resetn pulsed low mid-stream with count=3:
  - Outputs zero immediately.
  - After release, the first new arrival is the head.
